// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 slave receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    DONE
  } spi_rx_state_t;

  localparam int SPI_FRAME_BITS_DEFAULT  = 24;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a delay flop
// so rising/falling edges can be detected on the synchronised level.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   dly_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= {SYNC_STAGES{RST_VAL}};
      dly_p1  <= RST_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Edge detect between the last synchroniser stage and the delay flop
  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~dly_p1;
  assign fall  = ~level & dly_p1;

endmodule

// File: rtl/spi_slave_mode0_rx.sv
// SPI mode-0 slave: oversamples SCLK/CS/MOSI on clk, receives MSB-first frames
// and shifts a response word out on MISO in the same frame.
module spi_slave_mode0_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = SPI_FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  tx_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic mosi_lvl;

  spi_rx_state_t         state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_in;
  logic [FRAME_BITS-1:0] shift_out;
  logic                  overrun;

  // CS synchroniser starts low so a reset taken mid-frame waits for a real idle
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .level(sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (CS),
    .level(cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_p0 <= '0;
    else     mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], MOSI};
  end

  assign mosi_lvl = mosi_sync_p0[SYNC_STAGES-1];

  // Frame state machine; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      bit_cnt   <= '0;
      overrun   <= 1'b0;
      MISO      <= 1'b0;
      miso_oe   <= 1'b0;
      tx_load   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= ~cs_lvl && (state != WAIT_IDLE);

      case (state)
        WAIT_IDLE: begin
          MISO <= 1'b0;
          if (cs_lvl && !sclk_lvl) state <= IDLE;
        end

        IDLE: begin
          MISO    <= 1'b0;
          overrun <= 1'b0;
          if (cs_fall) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            tx_load   <= 1'b1;
            shift_out <= tx_data;
            MISO      <= tx_data[FRAME_BITS-1];
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            // Short frame, or CS and SCLK rising together: drop the word
            frame_err <= 1'b1;
            MISO      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shift_in <= {shift_in[FRAME_BITS-2:0], mosi_lvl};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_LAST) begin
              rx_data  <= {shift_in[FRAME_BITS-2:0], mosi_lvl};
              rx_valid <= 1'b1;
              MISO     <= 1'b0;
              state    <= DONE;
            end
          end else if (sclk_fall && bit_cnt != CNT_FULL) begin
            shift_out <= shift_out << 1;
            MISO      <= shift_out[FRAME_BITS-2];
          end
        end

        DONE: begin
          MISO <= 1'b0;
          if (cs_rise) begin
            frame_err <= overrun;
            overrun   <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_mode0_rx.sv
// Scoreboard bench for spi_slave_mode0_rx: a bit-level SPI master drives frames,
// a frame-level model predicts results, and a monitor checks DUT strobes.
module tb_spi_slave_mode0_rx;

  localparam int FB   = 24;
  localparam int HALF = 500;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          MISO, miso_oe, tx_load, rx_valid, frame_err;
  logic [FB-1:0] tx_data = '0;
  logic [FB-1:0] rx_data;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_extra = 0, err_seen = 0, load_seen = 0, oe_seen = 0, miso_bad = 0;
  int err_exp  = 0, load_exp = 0;
  logic [FB-1:0] exp_rx[$];
  logic [FB-1:0] last_good = '0;

  spi_slave_mode0_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .SCLK     (sclk),
    .CS       (cs),
    .MOSI     (mosi),
    .MISO     (MISO),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Monitor: compares each received word against the scoreboard, counts strobes
  always @(posedge clk) begin
    #1;
    if (rx_valid) begin
      if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      else rx_extra++;
    end
    if (frame_err) err_seen++;
    if (tx_load) load_seen++;
    if (miso_oe) oe_seen++;
    if (!miso_oe && MISO) miso_bad++;
  end

  // Frame-level model: seq holds the bits in send order from bit 31 downward
  task automatic model_frame(input logic [31:0] seq, input int nbits, input int rst_after);
    load_exp++;
    if (rst_after > 0) begin
      last_good = '0;
    end else begin
      if (nbits >= FB) begin
        exp_rx.push_back(seq[31:8]);
        last_good = seq[31:8];
      end
      if (nbits != FB) err_exp++;
    end
  endtask

  function automatic logic [31:0] miso_expect(input logic [FB-1:0] tx, input int nbits);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < nbits; i++) e = {e[30:0], (i < FB) ? tx[FB-1-i] : 1'b0};
    return e;
  endfunction

  task automatic spi_frame(input logic [FB-1:0] tx, input logic [31:0] seq, input int nbits,
                           input int rst_after, input int gap);
    logic [31:0] got;
    got = '0;
    model_frame(seq, nbits, rst_after);
    tx_data = tx;
    cs = 1'b0;
    mosi = seq[31];
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      got = {got[30:0], MISO};
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
      mosi = (i < 31) ? seq[30-i] : 1'b0;
      if (rst_after > 0 && i == rst_after - 1) begin
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst rx_data", 32'(rx_data), 32'h0);
        check("midrst miso_oe", 32'(miso_oe), 32'h0);
        #7;
      end
      #(HALF);
    end
    cs = 1'b1;
    if (rst_after == 0) check("miso_word", got, miso_expect(tx, nbits));
    #(gap);
  endtask

  task automatic end_test(input string tag);
    #2000;
    check({tag, " rx_pending"}, 32'(exp_rx.size()), 32'h0);
    check({tag, " rx_extra"}, rx_extra, 0);
    check({tag, " frame_err"}, err_seen, err_exp);
    check({tag, " tx_load"}, load_seen, load_exp);
    check({tag, " rx_hold"}, 32'(rx_data), 32'(last_good));
    exp_rx.delete();
    rx_extra = 0; err_seen = 0; err_exp = 0; load_seen = 0; load_exp = 0;
  endtask

  initial begin
    logic [31:0] seq;
    int nb, gsel, gap;

    repeat (4) @(negedge clk);
    check("reset MISO", 32'(MISO), 0);
    check("reset miso_oe", 32'(miso_oe), 0);
    check("reset tx_load", 32'(tx_load), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #7;

    spi_frame(24'hA5C33C, {24'h018000, 8'h00}, FB, 0, 1000);
    end_test("t1");

    spi_frame(24'h5A5A5A, $urandom, 10, 0, 1000);
    end_test("t2");

    spi_frame(24'h111111, {24'hFFFFFF, 8'h00}, FB, 0, 40);
    spi_frame(24'h222222, {24'h000001, 8'h00}, FB, 0, 1000);
    end_test("t3");

    spi_frame(24'h333333, $urandom, FB, 8, 1000);
    spi_frame(24'h444444, {24'h123456, 8'h00}, FB, 0, 1000);
    end_test("t4");

    spi_frame(24'hC0FFEE, {24'hABCDEF, 8'h80}, FB + 1, 0, 1000);
    end_test("t5");

    oe_seen = 0;
    for (int i = 0; i < 30; i++) begin
      mosi = 1'(($urandom));
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
      #(HALF);
    end
    check("t6 miso_oe", oe_seen, 0);
    end_test("t6");

    for (int k = 0; k < 10; k++) begin
      seq  = $urandom;
      gsel = $urandom_range(0, 3);
      if (gsel < 2)       nb = FB;
      else if (gsel == 2) nb = $urandom_range(1, FB - 1);
      else                nb = $urandom_range(FB + 1, FB + 3);
      case ($urandom_range(0, 2))
        0:       gap = 40;
        1:       gap = 200;
        default: gap = 1000;
      endcase
      spi_frame(24'($urandom), seq, nb, 0, gap);
    end
    end_test("rand");

    check("miso_gated", miso_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
